// File: rtl/mem_pkg.sv
// Shared memory-access definitions: funct3 size codes, sequencer states and
// small helpers for alignment and access width.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_BYTE = 3'd0,
    MEM_HALF = 3'd1,
    MEM_WORD = 3'd2,
    MEM_LBU  = 3'd4,
    MEM_LHU  = 3'd5
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Codes 3, 6 and 7 fall into the default arm and behave as a word.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      MEM_BYTE, MEM_LBU: return 1'b0;
      MEM_HALF, MEM_LHU: return addr_lo[0];
      default:           return addr_lo != 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] bytes_of(input logic [2:0] size);
    case (size)
      MEM_BYTE, MEM_LBU: return 3'd1;
      MEM_HALF, MEM_LHU: return 3'd2;
      default:           return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load data according to the funct3 size.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      MEM_BYTE: data = {{24{raw[7]}}, raw[7:0]};
      MEM_LBU:  data = {24'h0, raw[7:0]};
      MEM_HALF: data = {{16{raw[15]}}, raw[15:0]};
      MEM_LHU:  data = {16'h0, raw[15:0]};
      default:  data = raw;
    endcase
  end

endmodule

// File: rtl/mem_align_sequencer.sv
// Load/store front end for the byte-addressable data memory: aligned accesses
// pass straight through, misaligned ones are replayed as byte operations.
//
// state | meaning
// IDLE  | ready; aligned requests hit memory in the accept cycle
// SPLIT | one byte op per cycle, counter selects the byte lane
// RESP  | one-cycle response pulse, not ready
module mem_align_sequencer
  import mem_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_size_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic [2:0]        mem_size_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  state_e            state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              lat_we;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_wdata;
  logic [2:0]        lat_size;
  logic [DWIDTH-1:0] asm_data;

  logic              req_mis;
  logic [DWIDTH-1:0] split_word;
  logic [DWIDTH-1:0] ext_raw;
  logic [2:0]        ext_size;
  logic [DWIDTH-1:0] ext_data;

  assign req_mis     = is_misaligned(req_addr_i[1:0], req_size_i);
  // Held off during reset so nothing is accepted while the FSM is being cleared.
  assign req_ready_o = (state == IDLE) && !rst;

  always_comb begin
    split_word = asm_data;
    split_word[{cnt, 3'b000} +: 8] = mem_data_i[7:0];
  end

  assign ext_raw  = (state == SPLIT) ? split_word : mem_data_i;
  assign ext_size = (state == SPLIT) ? lat_size : req_size_i;

  load_extend u_load_extend (
    .raw  (ext_raw),
    .size (ext_size),
    .data (ext_data)
  );

  // Memory port is combinational so an aligned access completes in its accept cycle.
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_size_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid_i && !req_mis) begin
            mem_addr_o     = req_addr_i;
            mem_size_o     = req_we_i ? (req_size_i & 3'b011) : req_size_i;
            mem_data_o     = req_we_i ? req_wdata_i : '0;
            mem_read_en_o  = !req_we_i;
            mem_write_en_o = req_we_i;
          end
        end
        SPLIT: begin
          mem_addr_o     = lat_addr + AWIDTH'(cnt);
          mem_size_o     = MEM_BYTE;
          mem_data_o     = lat_we ? DWIDTH'(lat_wdata[{cnt, 3'b000} +: 8]) : '0;
          mem_read_en_o  = !lat_we;
          mem_write_en_o = lat_we;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= '0;
      asm_data     <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (!req_mis) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_rdata_o <= req_we_i ? '0 : ext_data;
            end else if (MISALIGN_EN != 0) begin
              state     <= SPLIT;
              cnt       <= '0;
              last      <= 2'(bytes_of(req_size_i) - 3'd1);
              lat_we    <= req_we_i;
              lat_addr  <= req_addr_i;
              lat_wdata <= req_wdata_i;
              lat_size  <= req_size_i;
              asm_data  <= '0;
            end else begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end
          end
        end
        SPLIT: begin
          asm_data <= split_word;
          if (cnt == last) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= lat_we ? '0 : ext_data;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          cnt          <= '0;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_sequencer.sv
// Self-checking bench: byte-array memory behind the sequencer, plus a
// byte-level reference model of memory contents and response timing.
module tb_mem_align_sequencer;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [2:0]  mem_size;
  logic        mem_rd, mem_wr;

  logic        req_valid_b, req_ready_b, req_we_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic [2:0]  req_size_b;
  logic        resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;
  logic [31:0] mem_addr_b, mem_data_b;
  logic [2:0]  mem_size_b;
  logic        mem_rd_b, mem_wr_b;
  logic [31:0] mem_rdata_b;

  assign mem_rdata_b = 32'h5A5A_5A5A;

  mem_align_sequencer #(.AWIDTH(32), .DWIDTH(32), .MISALIGN_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_size_o(mem_size),
    .mem_read_en_o(mem_rd), .mem_write_en_o(mem_wr), .mem_data_i(mem_rdata)
  );

  mem_align_sequencer #(.AWIDTH(32), .DWIDTH(32), .MISALIGN_EN(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_we_i(req_we_b),
    .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b), .req_size_i(req_size_b),
    .resp_valid_o(resp_valid_b), .resp_rdata_o(resp_rdata_b), .resp_err_o(resp_err_b),
    .mem_addr_o(mem_addr_b), .mem_data_o(mem_data_b), .mem_size_o(mem_size_b),
    .mem_read_en_o(mem_rd_b), .mem_write_en_o(mem_wr_b), .mem_data_i(mem_rdata_b)
  );

  int checks = 0;
  int errors = 0;

  // Physical memory (written only by DUT stores) and the reference copy.
  logic [7:0] mem [1024] = '{default: 8'h00};
  logic [7:0] model_mem [1024] = '{default: 8'h00};

  int rd_ops = 0, wr_ops = 0, both_ops = 0, resp_cnt = 0, ops_b = 0;

  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'd0) return 1;
    if (s[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  always_comb begin
    mem_rdata = '0;
    if (mem_rd)
      for (int k = 0; k < 4; k++)
        if (k < nbytes(mem_size)) mem_rdata[8*k +: 8] = mem[mem_addr[9:0] + 10'(k)];
  end

  always @(posedge clk) begin
    if (mem_rd) rd_ops++;
    if (mem_wr) begin
      wr_ops++;
      for (int k = 0; k < 4; k++)
        if (k < nbytes(mem_size)) mem[mem_addr[9:0] + 10'(k)] <= mem_data[8*k +: 8];
    end
    if (mem_rd && mem_wr) both_ops++;
    if (resp_valid) resp_cnt++;
    if (mem_rd_b || mem_wr_b) ops_b++;
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < nbytes(size); k++) w[8*k +: 8] = model_mem[addr[9:0] + 10'(k)];
    case (size)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd4: return {24'h0, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd5: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] size, input int nmax);
    for (int k = 0; k < nbytes(size) && k < nmax; k++)
      model_mem[addr[9:0] + 10'(k)] = wdata[8*k +: 8];
  endtask

  function automatic logic model_mis(input logic [31:0] addr, input logic [2:0] size);
    int n;
    n = nbytes(size);
    return (n > 1) && ((int'(addr[1:0]) % n) != 0);
  endfunction

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output int lat, output logic [31:0] rdata,
                         output logic err, output int nrd, output int nwr, output int nboth);
    int g, rd0, wr0, b0;
    lat = -1; rdata = 'x; err = 'x; nrd = -1; nwr = -1; nboth = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    rd0 = rd_ops; wr0 = wr_ops; b0 = both_ops;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
      lat = -1;
    end
    rdata = resp_rdata; err = resp_err;
    nrd = rd_ops - rd0; nwr = wr_ops - wr0; nboth = both_ops - b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_size_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b err=%b rdata=%h required 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_data, mem_size} !== 69'h0) begin
      errors++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h data=%h size=%0d required 0",
               mem_rd, mem_wr, mem_addr, mem_data, mem_size);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || req_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b ready_b=%b required 1", req_ready, req_ready_b);
    end
  endtask

  task automatic test_aligned_lw();
    int lat, nrd, nwr, nb; logic [31:0] rd; logic err;
    run_req(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 3'd2, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h4, 32'hDEAD_BEEF, 3'd2, 4);
    run_req(1'b0, BASE + 32'h4, 32'h0, 3'd2, lat, rd, err, nrd, nwr, nb);
    checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL aligned_lw_data: rdata=%h err=%b required deadbeef 0", rd, err);
    end
    checks++;
    if (lat != 1 || nrd != 1 || nwr != 0) begin
      errors++; $display("FAIL aligned_lw_timing: lat=%0d reads=%0d writes=%0d required 1 1 0", lat, nrd, nwr);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_pulse_width: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_misaligned_sw();
    int lat, nrd, nwr, nb; logic [31:0] rd; logic err;
    logic [31:0] got, exp;
    run_req(1'b1, BASE + 32'h1, 32'h1122_3344, 3'd2, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h1, 32'h1122_3344, 3'd2, 4);
    checks++;
    if (lat != 5 || nwr != 4 || nrd != 0 || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL mis_sw_timing: lat=%0d writes=%0d reads=%0d err=%b rdata=%h required 5 4 0 0 0",
               lat, nwr, nrd, err, rd);
    end
    got = {mem[4], mem[3], mem[2], mem[1]};
    exp = 32'h1122_3344;
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL mis_sw_bytes: mem[4:1]=%h required %h", got, exp);
    end
  endtask

  task automatic test_misaligned_lh();
    int lat, nrd, nwr, nb; logic [31:0] rd; logic err;
    run_req(1'b1, BASE + 32'h3, 32'h0000_0080, 3'd0, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h3, 32'h80, 3'd0, 4);
    run_req(1'b1, BASE + 32'h4, 32'h0000_00FF, 3'd0, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h4, 32'hFF, 3'd0, 4);
    run_req(1'b0, BASE + 32'h3, 32'h0, 3'd1, lat, rd, err, nrd, nwr, nb);
    checks++;
    if (rd !== 32'hFFFF_FF80 || lat != 3 || nrd != 2 || nwr != 0) begin
      errors++;
      $display("FAIL mis_lh: rdata=%h lat=%0d reads=%0d writes=%0d required ffffff80 3 2 0", rd, lat, nrd, nwr);
    end
    run_req(1'b0, BASE + 32'h3, 32'h0, 3'd5, lat, rd, err, nrd, nwr, nb);
    checks++;
    if (rd !== 32'h0000_FF80 || lat != 3 || nrd != 2) begin
      errors++; $display("FAIL mis_lhu: rdata=%h lat=%0d reads=%0d required 0000ff80 3 2", rd, lat, nrd);
    end
  endtask

  task automatic test_no_misalign();
    int lat, ops0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_valid_b = 1'b1; req_we_b = 1'b0; req_size_b = 3'd2; req_wdata_b = '0;
      req_addr_b = (t == 0) ? BASE + 32'h2 : BASE + 32'h8;
      ops0 = ops_b;
      @(posedge clk);
      #1 req_valid_b = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!resp_valid_b && lat < 20);
      checks++;
      if (t == 0) begin
        if (lat != 1 || resp_err_b !== 1'b1 || resp_rdata_b !== 32'h0 || ops_b != ops0) begin
          errors++;
          $display("FAIL no_mis_err: lat=%0d err=%b rdata=%h ops=%0d required 1 1 0 0",
                   lat, resp_err_b, resp_rdata_b, ops_b - ops0);
        end
      end else begin
        if (lat != 1 || resp_err_b !== 1'b0 || resp_rdata_b !== 32'h5A5A_5A5A || ops_b - ops0 != 1) begin
          errors++;
          $display("FAIL no_mis_aligned: lat=%0d err=%b rdata=%h ops=%0d required 1 0 5a5a5a5a 1",
                   lat, resp_err_b, resp_rdata_b, ops_b - ops0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_split();
    int lat, nrd, nwr, nb, w0, r0, g; logic [31:0] rd; logic err;
    run_req(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 3'd2, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h20, 32'hAABB_CCDD, 3'd2, 4);
    run_req(1'b1, BASE + 32'h24, 32'h0102_0304, 3'd2, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h24, 32'h0102_0304, 3'd2, 4);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h21; req_wdata = 32'h9988_7766; req_size = 3'd2;
    w0 = wr_ops; r0 = resp_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (wr_ops - w0 < 2 && g < 10);
    model_store(BASE + 32'h21, 32'h9988_7766, 3'd2, 2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_data, mem_size, resp_valid, resp_err, resp_rdata} !== 103'h0) begin
      errors++;
      $display("FAIL abort_outputs: wr=%b rd=%b addr=%h valid=%b required all 0", mem_wr, mem_rd, mem_addr, resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: ready=%b required 1", req_ready);
    end
    checks++;
    if (wr_ops - w0 != 2 || resp_cnt != r0) begin
      errors++;
      $display("FAIL abort_writes: writes=%0d responses=%0d required 2 0", wr_ops - w0, resp_cnt - r0);
    end
    for (int k = 32'h20; k <= 32'h24; k++) begin
      checks++;
      if (mem[k] !== model_mem[k]) begin
        errors++; $display("FAIL abort_mem[%0h]: got %h required %h", k, mem[k], model_mem[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nrd, nwr, nb; logic [31:0] rd; logic err;
    run_req(1'b1, BASE + 32'h10, 32'h0000_00AB, 3'd0, lat, rd, err, nrd, nwr, nb);
    model_store(BASE + 32'h10, 32'hAB, 3'd0, 4);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_ready: ready=%b required 0 during response", req_ready);
    end
    run_req(1'b0, BASE + 32'h10, 32'h0, 3'd4, lat, rd, err, nrd, nwr, nb);
    checks++;
    if (rd !== 32'h0000_00AB || lat != 1 || nrd != 1) begin
      errors++; $display("FAIL b2b_lbu: rdata=%h lat=%0d reads=%0d required 000000ab 1 1", rd, lat, nrd);
    end
  endtask

  task automatic test_random();
    int lat, nrd, nwr, nb, elat, eops;
    logic [31:0] rd, addr, wdata, erd;
    logic err, we;
    logic [2:0] size;
    for (int i = 0; i < 80; i++) begin
      addr  = BASE + 32'($urandom_range(0, 1000));
      we    = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      erd   = we ? 32'h0 : model_load(addr, size);
      elat  = model_mis(addr, size) ? 1 + nbytes(size) : 1;
      eops  = model_mis(addr, size) ? nbytes(size) : 1;
      run_req(we, addr, wdata, size, lat, rd, err, nrd, nwr, nb);
      checks++;
      if (rd !== erd || err !== 1'b0) begin
        errors++;
        $display("FAIL rand_data[%0d]: we=%b addr=%h size=%0d rdata=%h err=%b required %h 0",
                 i, we, addr, size, rd, err, erd);
      end
      checks++;
      if (lat != elat || nb != 0 || (we ? (nwr != eops || nrd != 0) : (nrd != eops || nwr != 0))) begin
        errors++;
        $display("FAIL rand_timing[%0d]: lat=%0d rd=%0d wr=%0d both=%0d required lat %0d ops %0d",
                 i, lat, nrd, nwr, nb, elat, eops);
      end
      if (we) begin
        model_store(addr, wdata, size, 4);
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (mem[addr[9:0] + 10'(k)] !== model_mem[addr[9:0] + 10'(k)]) begin
            errors++;
            $display("FAIL rand_mem[%0d]: byte %h got %h required %h", i, addr + 32'(k),
                     mem[addr[9:0] + 10'(k)], model_mem[addr[9:0] + 10'(k)]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_misaligned_sw();
    test_misaligned_lh();
    test_no_misalign();
    test_reset_mid_split();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
